pc_unit: RTL and testbench

Parametrised program-counter unit, the successor to the plain load/hold `pc` register. It keeps the fetch address and computes the next one internally: sequential increment, branch/jump load, call/return through a small return-address stack (RAS), and trap redirect with exception-PC capture. It sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_unit.sv | 110 +++++++++++
 tb/tb_pc_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequential step, branch/call/return/trap redirect,
// and a circular return-address stack with overflow wrap and sticky underflow.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        branch_taken,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        trap,
  input  logic [WIDTH-1:0]            target,
  output logic [WIDTH-1:0]            pc_out,
  output logic [WIDTH-1:0]            epc,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_empty,
  output logic                        ras_full,
  output logic                        ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP_INC = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             underflow_q, underflow_d;

  logic             ras_we;
  logic [WIDTH-1:0] ras_wdata;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_top;

  assign pc_plus = pc_q + STEP_INC;
  // The pointer names the next free slot, so the top entry sits just below it.
  assign ras_top = ras_mem[ptr_q - PTR_W'(1)];

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    ras_we      = 1'b0;
    ras_wdata   = pc_plus;
    if (enable) begin
      if (trap) begin
        pc_d  = TRAP_VECTOR;
        epc_d = pc_q;
      end else if (ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_top;
          ptr_d = ptr_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d        = pc_plus;
          underflow_d = 1'b1;
        end
      end else if (call) begin
        ras_we = 1'b1;
        pc_d   = target;
        ptr_d  = ptr_q + PTR_W'(1);
        // A full stack overwrites its oldest entry; the count just saturates.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (branch_taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ptr_q] <= ras_wdata;
  end

  assign pc_out        = pc_q;
  assign epc           = epc_q;
  assign ras_count     = cnt_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_MAX);
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random control
// traffic, all compared against a queue-based return-stack model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, branch_taken = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] pc_out, epc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_underflow;

  logic       en8 = 1'b0, br8 = 1'b0;
  logic [7:0] tgt8 = '0;
  logic [7:0] pc8, epc8;
  logic [2:0] cnt8;
  logic       empty8, full8, uf8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: PC as plain arithmetic, RAS as a bounded queue.
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  bit          m_uf;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .branch_taken(branch_taken),
    .call(call), .ret(ret), .trap(trap), .target(target),
    .pc_out(pc_out), .epc(epc), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  pc_unit #(.WIDTH(8), .TRAP_VECTOR(8'h80)) dut8 (
    .clk(clk), .rst(rst), .enable(en8), .branch_taken(br8),
    .call(1'b0), .ret(1'b0), .trap(1'b0), .target(tgt8),
    .pc_out(pc8), .epc(epc8), .ras_count(cnt8),
    .ras_empty(empty8), .ras_full(full8), .ras_underflow(uf8)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_ras.delete();
    m_uf  = 1'b0;
  endtask

  task automatic modelStep(input bit en, input bit br, input bit ca, input bit re,
                           input bit tr, input logic [31:0] tgt);
    if (!en) return;
    if (tr) begin
      m_epc = m_pc;
      m_pc  = 32'h100;
    end else if (re) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = m_pc + 32'd4;
        m_uf = 1'b1;
      end
    end else if (ca) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
      m_pc = tgt;
    end else if (br) begin
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".pc"},        pc_out, m_pc);
    checkValue({tag, ".epc"},       epc, m_epc);
    checkValue({tag, ".count"},     32'(ras_count), 32'(m_ras.size()));
    checkValue({tag, ".empty"},     32'(ras_empty), 32'(m_ras.size() == 0));
    checkValue({tag, ".full"},      32'(ras_full), 32'(m_ras.size() == 4));
    checkValue({tag, ".underflow"}, 32'(ras_underflow), 32'(m_uf));
  endtask

  task automatic applyStimulus(input string tag, input bit en, input bit br, input bit ca,
                               input bit re, input bit tr, input logic [31:0] tgt);
    enable       = en;
    branch_taken = br;
    call         = ca;
    ret          = re;
    trap         = tr;
    target       = tgt;
    @(posedge clk);
    modelStep(en, br, ca, re, tr, tgt);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    modelReset();
    // Asynchronous reset before any clock edge has occurred
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] sequential step and hold");
    applyStimulus("step1", 1, 0, 0, 0, 0, 32'h0);
    applyStimulus("step2", 1, 0, 0, 0, 0, 32'h0);
    applyStimulus("step3", 1, 0, 0, 0, 0, 32'h0);
    checkValue("pc_is_12", pc_out, 32'd12);
    applyStimulus("hold1", 0, 0, 0, 0, 0, 32'h0);
    applyStimulus("hold2", 0, 1, 1, 1, 1, 32'hDEAD_BEE0);
    checkValue("hold_pc_12", pc_out, 32'd12);

    $display("[TB] branch versus trap");
    applyStimulus("br_40", 1, 1, 0, 0, 0, 32'h40);
    applyStimulus("br_200", 1, 1, 0, 0, 0, 32'h200);
    checkValue("branch_pc", pc_out, 32'h200);
    applyStimulus("trap_br", 1, 1, 0, 0, 1, 32'h300);
    checkValue("trap_pc", pc_out, 32'h100);
    checkValue("trap_epc", epc, 32'h200);

    $display("[TB] call/return nesting");
    applyStimulus("br_10", 1, 1, 0, 0, 0, 32'h10);
    applyStimulus("call_80", 1, 0, 1, 0, 0, 32'h80);
    checkValue("call1_count", 32'(ras_count), 32'd1);
    applyStimulus("call_c0", 1, 1, 1, 0, 0, 32'hC0);
    checkValue("call2_count", 32'(ras_count), 32'd2);
    applyStimulus("ret1", 1, 0, 0, 1, 0, 32'h0);
    checkValue("ret1_pc", pc_out, 32'h84);
    applyStimulus("ret2", 1, 0, 0, 1, 0, 32'h0);
    checkValue("ret2_pc", pc_out, 32'h14);
    checkValue("ret2_empty", 32'(ras_empty), 32'd1);

    $display("[TB] RAS overflow and underflow");
    for (int i = 1; i <= 5; i++)
      applyStimulus("ovf_call", 1, 0, 1, 0, 0, 32'(i) << 12);
    checkValue("ovf_full", 32'(ras_full), 32'd1);
    checkValue("ovf_count", 32'(ras_count), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      applyStimulus("ovf_ret", 1, 0, 0, 1, 0, 32'h0);
      checkValue("ovf_ret_pc", pc_out, (32'(i) << 12) + 32'd4);
    end
    applyStimulus("uf_ret", 1, 0, 0, 1, 0, 32'h0);
    checkValue("uf_pc", pc_out, 32'h1008);
    checkValue("uf_flag", 32'(ras_underflow), 32'd1);

    $display("[TB] simultaneous call and ret");
    applyStimulus("call_500", 1, 0, 1, 0, 0, 32'h500);
    applyStimulus("call_ret", 1, 0, 1, 1, 0, 32'h900);
    checkValue("call_ret_pc", pc_out, 32'h100C);
    checkValue("call_ret_count", 32'(ras_count), 32'd0);
    checkValue("uf_sticky", 32'(ras_underflow), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom);
    end

    $display("[TB] mid-operation reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset2");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("mr_call1", 1, 0, 1, 0, 0, 32'h300);
    applyStimulus("mr_call2", 1, 0, 1, 0, 0, 32'h340);
    checkValue("mr_count2", 32'(ras_count), 32'd2);
    enable = 1'b0;
    call   = 1'b0;
    #3 rst = 1'b1;
    #1;
    modelReset();
    checkValue("mr_pc_async", pc_out, 32'h0);
    checkValue("mr_count_async", 32'(ras_count), 32'd0);
    checkOutput("mr_async");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("mr_resume", 1, 0, 0, 0, 0, 32'h0);
    checkValue("mr_resume_pc", pc_out, 32'h4);

    $display("[TB] 8-bit wrap");
    @(negedge clk);
    en8  = 1'b1;
    br8  = 1'b1;
    tgt8 = 8'hFC;
    @(posedge clk);
    #1;
    checkValue("w8_load", 32'(pc8), 32'hFC);
    br8 = 1'b0;
    @(posedge clk);
    #1;
    checkValue("w8_wrap", 32'(pc8), 32'h00);
    checkValue("w8_uf", 32'(uf8), 32'd0);
    en8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
